serial_deserializer: RTL and testbench
======================================

SERIAL_DESERIALIZER -- requirements
Module: serial_deserializer

Interface
REQ-001 Parameter WIDTH, default 8: number of bits per frame, legal range 2..16.
REQ-002 Parameter LSB_FIRST, default 1: 1 means the first received bit becomes data bit 0; 0 means the first received bit becomes data bit WIDTH-1.
REQ-003 clk  input  1  clock; all state SHALL change on the rising edge only.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start_i  input  1  begin a new frame and discard any partial frame.
REQ-006 enable_i  input  1  serial_i holds a valid bit this cycle.
REQ-007 serial_i  input  1  serial data bit.
REQ-008 ready_i  input  1  consumer accepts data_o this cycle.
REQ-009 data_o  output  WIDTH  last completed word, held in a dedicated output register.
REQ-010 valid_o  output  1  data_o holds an unconsumed word.
REQ-011 busy_o  output  1  high while in state SHIFT.
REQ-012 bit_cnt_o  output  ceil(log2(WIDTH+1))  bits captured in the current frame.
REQ-013 overrun_o  output  1  sticky flag: a completed word was lost.

Function
REQ-014 The block SHALL implement two states: IDLE and SHIFT.
REQ-015 In IDLE, start_i=1 SHALL move the block to SHIFT and clear the shift register and bit counter to 0.
REQ-016 In IDLE, enable_i SHALL be ignored.
REQ-017 In SHIFT, each cycle with enable_i=1 SHALL capture serial_i into the shift register and increment bit_cnt_o.
- LSB_FIRST=1: sreg <= {serial_i, sreg[WIDTH-1:1]}.
- LSB_FIRST=0: sreg <= {sreg[WIDTH-2:0], serial_i}.
REQ-018 In SHIFT, cycles with enable_i=0 SHALL hold all state (gaps allowed, no timeout).
REQ-019 On the rising edge that captures the WIDTH-th bit, the block SHALL:
- load the assembled word into data_o,
- set valid_o=1,
- clear bit_cnt_o to 0,
- return to IDLE.
REQ-020 The first valid word SHALL therefore be visible on data_o/valid_o in the cycle after the WIDTH-th enable_i.
REQ-021 valid_o/ready_i handshake:
- valid_o SHALL stay high and data_o stable until a cycle with valid_o=1 and ready_i=1.
- valid_o SHALL then clear on that edge.
- ready_i with valid_o=0 SHALL have no effect.
REQ-022 If a word completes while valid_o=1 and ready_i=1 in the same cycle, data_o SHALL take the new word, valid_o SHALL stay 1, and overrun_o SHALL NOT change.
REQ-023 If a word completes while valid_o=1 and ready_i=0, the new word SHALL be discarded, data_o SHALL be retained, and overrun_o SHALL be set.
REQ-024 overrun_o SHALL stay set until reset.
REQ-025 start_i in SHIFT SHALL abort the frame: counter and shift register cleared, state remains SHIFT.
REQ-026 start_i SHALL have priority over enable_i in the same cycle; that cycle's serial_i SHALL NOT be captured.
REQ-027 start_i SHALL NOT affect data_o, valid_o or overrun_o.
REQ-028 busy_o, valid_o, overrun_o, data_o and bit_cnt_o SHALL be driven directly from registers, with no combinational path from any input.

Reset
REQ-029 While rst=1, the block SHALL hold: state=IDLE, shift register=0, bit_cnt_o=0, data_o=0, valid_o=0, busy_o=0, overrun_o=0.
REQ-030 Reset asserted mid-frame SHALL discard the partial frame; after release, enable_i SHALL be ignored until start_i.
REQ-031 The first edge after reset release SHALL act on its inputs normally.

Verification
REQ-032 WIDTH=8, LSB_FIRST=1: start_i, then 8 enables with serial_i = 1,0,1,0,0,1,0,1 -> data_o=0xA5, valid_o=1 in the cycle after the 8th enable, busy_o=0.
REQ-033 Same bit stream with idle gaps of 0-3 cycles between enables -> data_o=0xA5; bit_cnt_o steps 1..7, then returns to 0.
REQ-034 start_i after 5 bits, then 8 bits encoding 0x3C -> data_o=0x3C with no trace of the aborted bits.
REQ-035 Word 0x11 pending with ready_i=0, then a second frame 0x22 completes -> data_o=0x11, overrun_o=1. Repeat with ready_i=1 on the completion cycle -> data_o=0x22, valid_o=1, overrun_o unchanged.
REQ-036 rst pulsed after 4 bits, then 8 enables without start_i -> valid_o stays 0 and bit_cnt_o stays 0; all outputs equal their reset values.
REQ-037 LSB_FIRST=0: bits 1,0,1,0,0,1,0,1 -> data_o=0xA5 (first bit in bit 7).

Source files
------------

// File: rtl/serial_deserializer.sv
// Serial-to-parallel frame receiver with a valid/ready output register
// and a sticky overrun flag for words dropped while the output is full.
module serial_deserializer #(
  parameter int WIDTH = 8,
  parameter bit LSB_FIRST = 1'b1,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             enable_i,
  input  logic             serial_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             busy_o,
  output logic [CW-1:0]    bit_cnt_o,
  output logic             overrun_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic [WIDTH-1:0] shifted;
  logic             done;

  always_comb begin
    if (LSB_FIRST) begin
      shifted = {serial_i, sreg_q[WIDTH-1:1]};
    end else begin
      shifted = {sreg_q[WIDTH-2:0], serial_i};
    end
  end

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    done    = 1'b0;

    if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = SHIFT;
          sreg_d  = '0;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (start_i) begin
          sreg_d = '0;
          cnt_d  = '0;
        end else if (enable_i) begin
          sreg_d = shifted;
          if (cnt_q == CW'(WIDTH - 1)) begin
            done    = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A word completing into a full, unconsumed output is dropped.
    if (done) begin
      if (!valid_q || ready_i) begin
        data_d  = shifted;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign busy_o    = (state_q == SHIFT);
  assign bit_cnt_o = cnt_q;
  assign overrun_o = ovr_q;

endmodule

// File: tb/tb_serial_deserializer.sv
// Directed bench: LSB-first and MSB-first instances share one stimulus.
module tb_serial_deserializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_i, enable_i, serial_i, ready_i;
  logic [7:0] data_o, m_data_o;
  logic       valid_o, busy_o, overrun_o;
  logic       m_valid_o, m_busy_o, m_overrun_o;
  logic [3:0] bit_cnt_o, m_bit_cnt_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_deserializer #(.WIDTH(8), .LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .rst(rst), .start_i(start_i), .enable_i(enable_i),
    .serial_i(serial_i), .ready_i(ready_i), .data_o(data_o),
    .valid_o(valid_o), .busy_o(busy_o), .bit_cnt_o(bit_cnt_o),
    .overrun_o(overrun_o)
  );

  serial_deserializer #(.WIDTH(8), .LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .rst(rst), .start_i(start_i), .enable_i(enable_i),
    .serial_i(serial_i), .ready_i(ready_i), .data_o(m_data_o),
    .valid_o(m_valid_o), .busy_o(m_busy_o), .bit_cnt_o(m_bit_cnt_o),
    .overrun_o(m_overrun_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    start_i  = 1'b0;
    enable_i = 1'b0;
    serial_i = 1'b0;
    ready_i  = 1'b0;
  endtask

  task automatic do_start();
    idle_in();
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
  endtask

  // Sends w LSB first; ready_i only on the final bit's cycle.
  task automatic send_word(input logic [7:0] w, input logic last_rdy);
    for (int i = 0; i < 8; i++) begin
      enable_i = 1'b1;
      serial_i = w[i];
      ready_i  = (i == 7) ? last_rdy : 1'b0;
      cyc();
    end
    idle_in();
  endtask

  task automatic consume();
    idle_in();
    ready_i = 1'b1;
    cyc();
    ready_i = 1'b0;
  endtask

  initial begin
    logic [7:0] a5;
    int gaps [8];
    a5 = 8'hA5;
    gaps = '{0, 3, 1, 2, 0, 3, 2, 1};
    rst = 1'b1;
    idle_in();
    cyc();
    cyc();
    chk("rst_data", data_o, 8'h00);
    chk("rst_valid", valid_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_cnt", bit_cnt_o, 4'd0);
    chk("rst_ovr", overrun_o, 1'b0);
    rst = 1'b0;

    // enables in IDLE are ignored
    enable_i = 1'b1;
    serial_i = 1'b1;
    cyc();
    chk("idle_en_cnt", bit_cnt_o, 4'd0);
    chk("idle_en_busy", busy_o, 1'b0);

    // basic frame 0xA5
    do_start();
    chk("start_busy", busy_o, 1'b1);
    chk("start_cnt", bit_cnt_o, 4'd0);
    send_word(a5, 1'b0);
    chk("a5_data", data_o, 8'hA5);
    chk("a5_valid", valid_o, 1'b1);
    chk("a5_busy", busy_o, 1'b0);
    chk("a5_cnt", bit_cnt_o, 4'd0);
    chk("a5_msb_data", m_data_o, 8'hA5);
    cyc();
    chk("a5_hold_valid", valid_o, 1'b1);
    consume();
    chk("a5_consumed", valid_o, 1'b0);
    ready_i = 1'b1;
    cyc();
    ready_i = 1'b0;
    chk("rdy_novalid", valid_o, 1'b0);

    // same stream with gaps
    do_start();
    for (int i = 0; i < 8; i++) begin
      for (int g = 0; g < gaps[i]; g++) begin
        idle_in();
        cyc();
        chk("gap_cnt_hold", bit_cnt_o, 4'(i));
      end
      enable_i = 1'b1;
      serial_i = a5[i];
      cyc();
      chk("gap_cnt", bit_cnt_o, (i == 7) ? 4'd0 : 4'(i + 1));
    end
    idle_in();
    chk("gap_data", data_o, 8'hA5);
    chk("gap_valid", valid_o, 1'b1);
    consume();

    // abort after 5 bits, start beats enable
    do_start();
    for (int i = 0; i < 5; i++) begin
      enable_i = 1'b1;
      serial_i = 1'b1;
      cyc();
    end
    chk("abort_cnt5", bit_cnt_o, 4'd5);
    start_i  = 1'b1;
    enable_i = 1'b1;
    serial_i = 1'b1;
    cyc();
    idle_in();
    chk("abort_cnt0", bit_cnt_o, 4'd0);
    chk("abort_busy", busy_o, 1'b1);
    chk("abort_data_kept", data_o, 8'hA5);
    send_word(8'h3C, 1'b0);
    chk("abort_data", data_o, 8'h3C);
    consume();

    // completion while full with ready: replace, no overrun
    do_start();
    send_word(8'h11, 1'b0);
    chk("w11_data", data_o, 8'h11);
    chk("w11_msb_data", m_data_o, 8'h88);
    do_start();
    send_word(8'h22, 1'b1);
    chk("rdy_repl_data", data_o, 8'h22);
    chk("rdy_repl_valid", valid_o, 1'b1);
    chk("rdy_repl_ovr", overrun_o, 1'b0);

    // completion while full without ready: drop, overrun
    do_start();
    send_word(8'h11, 1'b0);
    chk("ovr_data", data_o, 8'h22);
    chk("ovr_flag", overrun_o, 1'b1);
    chk("ovr_valid", valid_o, 1'b1);
    consume();
    chk("ovr_sticky", overrun_o, 1'b1);
    chk("ovr_cons_valid", valid_o, 1'b0);
    do_start();
    chk("ovr_start_keep", overrun_o, 1'b1);

    // async reset mid-frame
    for (int i = 0; i < 4; i++) begin
      enable_i = 1'b1;
      serial_i = 1'b1;
      cyc();
    end
    chk("pre_rst_cnt", bit_cnt_o, 4'd4);
    #2 rst = 1'b1;
    #1;
    chk("async_cnt", bit_cnt_o, 4'd0);
    chk("async_busy", busy_o, 1'b0);
    chk("async_ovr", overrun_o, 1'b0);
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      enable_i = 1'b1;
      serial_i = 1'b1;
      cyc();
      chk("post_rst_cnt", bit_cnt_o, 4'd0);
      chk("post_rst_valid", valid_o, 1'b0);
    end
    idle_in();
    chk("post_rst_data", data_o, 8'h00);
    chk("post_rst_busy", busy_o, 1'b0);
    chk("post_rst_ovr", overrun_o, 1'b0);

    // first edge after release acts normally
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    chk("first_edge_busy", busy_o, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
